branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Consumes the 24-bit set-less-than result word (value 24'd1 when a<b, else 24'd0) and an equality flag produced by the ALU compare path.
- Decides conditional branches and produces the redirect target PC.
- Drives a pipeline flush window of fixed length.
- Sits between the execute stage compare logic and the fetch-stage PC mux.

Parameters:
- DW, 24, datapath/PC width.
- FLUSH_CYCLES, 2, cycles flush is held high on a taken branch (legal range 1..7).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- br_valid  input  1  branch request valid.
- br_ready  output  1  unit can accept a request.
- br_op  input  2  00=BLT, 01=BGE, 10=BEQ, 11=BNE.
- sltres  input  DW  compare result word; nonzero means less-than.
- eq  input  1  operands equal.
- pc  input  DW  PC of the branch instruction.
- offset  input  DW  signed branch offset, two's complement.
- redirect  output  1  one-cycle pulse; fetch loads target_pc.
- target_pc  output  DW  resolved branch target.
- flush  output  1  squash younger pipeline stages.
- resolved  output  1  one-cycle pulse when a request completes, taken or not.
- taken  output  1  outcome of the last resolved branch; holds until the next resolve.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - br_ready=1; redirect, flush, resolved and taken all 0.
  - target_pc=0; flush counter=0.
- States: IDLE, EVAL, FLUSH, DONE.
- IDLE:
  - br_ready=1.
  - On br_valid && br_ready, capture br_op, sltres, eq, pc and offset into registers, then go to EVAL.
  - Inputs are sampled only at acceptance; later input changes are ignored.
- EVAL (br_ready=0):
  - Condition: lt = |sltres_q (any nonzero bit counts as true).
  - BLT is taken when lt; BGE when !lt; BEQ when eq_q; BNE when !eq_q.
  - target_pc <= pc_q + offset_q, modulo 2^DW; wrap-around is silent.
  - If taken: set flush=1, load counter with FLUSH_CYCLES, go to FLUSH.
  - If not taken: go to DONE; target_pc is still updated but redirect is not pulsed.
- FLUSH:
  - flush stays high and the counter decrements each cycle.
  - flush is high for exactly FLUSH_CYCLES cycles, the first being the cycle after EVAL.
  - When the counter reaches 1: drop flush next cycle and go to DONE.
  - redirect pulses high in the first FLUSH cycle only.
- DONE:
  - resolved=1 and taken is updated, for one cycle.
  - Return to IDLE; br_ready is 1 again in the following cycle.
- Latency:
  - Not taken: accept to resolved is 2 cycles.
  - Taken: accept to resolved is 2+FLUSH_CYCLES cycles.
- Throughput: at most one request in flight; back-to-back requests are separated by the DONE cycle.
- br_valid asserted while br_ready=0 is ignored. The requester must hold br_valid until it sees the handshake.
- Reset mid-operation: returns to IDLE immediately. flush and redirect drop asynchronously and the in-flight branch is discarded; no resolved pulse.
- Outputs are registered; there are no combinational paths from inputs to outputs except br_ready, which is decoded from state.

Optional Feature:
- Macro: BR_STATS_EN.
- When defined:
  - Adds outputs stat_taken [15:0] and stat_total [15:0], both cleared by rst.
  - stat_total increments on each DONE cycle; stat_taken increments on DONE when taken.
  - Both counters saturate at 16'hFFFF (no wrap).
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- BLT taken, FLUSH_CYCLES=2:
  - Stimulus: sltres=24'd1, pc=24'h000100, offset=24'h000010.
  - Expect: target_pc=24'h000110, redirect for 1 cycle, flush for 2 cycles, taken=1, resolved 4 cycles after accept.
- BLT not taken:
  - Stimulus: sltres=24'd0, pc=24'h000200, offset=24'h000004.
  - Expect: no redirect, no flush, taken=0, resolved 2 cycles after accept, target_pc=24'h000204.
- BNE backward with wrap:
  - Stimulus: eq=0, pc=24'h000004, offset=24'hFFFFF8.
  - Expect: target_pc=24'hFFFFFC, taken=1.
- Input change after accept:
  - Stimulus: BEQ with eq=1; change eq to 0 and br_valid to 1 during EVAL.
  - Expect: the branch still resolves taken, and the second request is accepted only after DONE.
- Reset mid-flush:
  - Stimulus: assert rst in the first FLUSH cycle.
  - Expect: flush=0 and br_ready=1 immediately, no resolved pulse, and the next request is processed normally.
- BR_STATS_EN:
  - Stimulus: 3 taken + 2 not-taken branches.
  - Expect: stat_taken=3, stat_total=5. Preloading near 16'hFFFF shows saturation.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches (BLT/BGE/BEQ/BNE) and drives redirect/flush to fetch.
// Optional macro BR_STATS_EN adds saturating taken/total branch counters.
`default_nettype none

module branch_resolve #(
    parameter int DW           = 24,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          br_valid,
    output logic          br_ready,
    input  logic [1:0]    br_op,
    input  logic [DW-1:0] sltres,
    input  logic          eq,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] offset,
    output logic          redirect,
    output logic [DW-1:0] target_pc,
    output logic          flush,
    output logic          resolved,
    output logic          taken
`ifdef BR_STATS_EN
    ,
    output logic [15:0]   stat_taken,
    output logic [15:0]   stat_total
`endif
);

    localparam logic [1:0] OP_BLT = 2'b00;
    localparam logic [1:0] OP_BGE = 2'b01;
    localparam logic [1:0] OP_BEQ = 2'b10;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [DW-1:0] slt_q, slt_d;
    logic          eq_q, eq_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] off_q, off_d;
    logic          outcome_q, outcome_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic          redirect_q, redirect_d;
    logic          resolved_q, resolved_d;
    logic          taken_q, taken_d;
    logic [DW-1:0] target_q, target_d;
`ifdef BR_STATS_EN
    logic [15:0]   stat_taken_q, stat_taken_d;
    logic [15:0]   stat_total_q, stat_total_d;
`endif

    logic w_lt;
    logic w_cond;

    // Any nonzero bit of the SLT word means less-than, not just bit 0.
    assign w_lt = |slt_q;

    always_comb begin
        w_cond = 1'b0;
        case (op_q)
            OP_BLT:  w_cond = w_lt;
            OP_BGE:  w_cond = ~w_lt;
            OP_BEQ:  w_cond = eq_q;
            default: w_cond = ~eq_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        slt_d      = slt_q;
        eq_d       = eq_q;
        pc_d       = pc_q;
        off_d      = off_q;
        outcome_d  = outcome_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        redirect_d = 1'b0;
        resolved_d = 1'b0;
        taken_d    = taken_q;
        target_d   = target_q;
`ifdef BR_STATS_EN
        stat_taken_d = stat_taken_q;
        stat_total_d = stat_total_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    op_d    = br_op;
                    slt_d   = sltres;
                    eq_d    = eq;
                    pc_d    = pc;
                    off_d   = offset;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                target_d  = pc_q + off_q;
                outcome_d = w_cond;
                if (w_cond) begin
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                    cnt_d      = FLUSH_INIT;
                    state_d    = S_FLUSH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    flush_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                resolved_d = 1'b1;
                taken_d    = outcome_q;
                state_d    = S_IDLE;
`ifdef BR_STATS_EN
                if (stat_total_q != 16'hFFFF) begin
                    stat_total_d = stat_total_q + 16'd1;
                end
                if (outcome_q && (stat_taken_q != 16'hFFFF)) begin
                    stat_taken_d = stat_taken_q + 16'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            slt_q      <= '0;
            eq_q       <= 1'b0;
            pc_q       <= '0;
            off_q      <= '0;
            outcome_q  <= 1'b0;
            cnt_q      <= 3'd0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
`ifdef BR_STATS_EN
            stat_taken_q <= 16'd0;
            stat_total_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            slt_q      <= slt_d;
            eq_q       <= eq_d;
            pc_q       <= pc_d;
            off_q      <= off_d;
            outcome_q  <= outcome_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
`ifdef BR_STATS_EN
            stat_taken_q <= stat_taken_d;
            stat_total_q <= stat_total_d;
`endif
        end
    end

    assign br_ready  = (state_q == S_IDLE);
    assign redirect  = redirect_q;
    assign target_pc = target_q;
    assign flush     = flush_q;
    assign resolved  = resolved_q;
    assign taken     = taken_q;
`ifdef BR_STATS_EN
    assign stat_taken = stat_taken_q;
    assign stat_total = stat_total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed + randomized checks of branch_resolve against a transaction-level model.
`default_nettype none

module tb_branch_resolve;

    localparam int DW = 24;
    localparam int F  = 2;

    logic          clk;
    logic          rst;
    logic          br_valid;
    logic          br_ready;
    logic [1:0]    br_op;
    logic [DW-1:0] sltres;
    logic          eq;
    logic [DW-1:0] pc;
    logic [DW-1:0] offset;
    logic          redirect;
    logic [DW-1:0] target_pc;
    logic          flush;
    logic          resolved;
    logic          taken;
`ifdef BR_STATS_EN
    logic [15:0]   stat_taken;
    logic [15:0]   stat_total;
`endif

    int checks = 0;
    int errors = 0;

    logic          last_taken;
    logic [DW-1:0] last_target;
    int            n_total;
    int            n_taken;

    branch_resolve #(.DW(DW), .FLUSH_CYCLES(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_op     (br_op),
        .sltres    (sltres),
        .eq        (eq),
        .pc        (pc),
        .offset    (offset),
        .redirect  (redirect),
        .target_pc (target_pc),
        .flush     (flush),
        .resolved  (resolved),
        .taken     (taken)
`ifdef BR_STATS_EN
        ,
        .stat_taken(stat_taken),
        .stat_total(stat_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_taken(input logic [1:0] op, input logic [DW-1:0] s, input logic e);
        logic lt;
        lt = (s != '0);
        case (op)
            2'b00:   return lt;
            2'b01:   return !lt;
            2'b10:   return e;
            default: return !e;
        endcase
    endfunction

    function automatic logic [DW-1:0] model_target(input logic [DW-1:0] p, input logic [DW-1:0] o);
        longint sum;
        sum = (longint'(p) + longint'(o)) % (longint'(1) << DW);
        return DW'(sum);
    endfunction

    // Called just after a negedge with the unit idle. If follow is set, br_valid stays
    // high during the busy window carrying the next request's fields.
    task automatic run_branch(input logic [1:0] op, input logic [DW-1:0] s, input logic e,
                              input logic [DW-1:0] p, input logic [DW-1:0] o,
                              input bit follow, input logic [1:0] nop, input logic [DW-1:0] ns,
                              input logic ne, input logic [DW-1:0] np, input logic [DW-1:0] no);
        logic          exp_tk;
        logic [DW-1:0] exp_tgt;
        int            lat;
        exp_tk  = model_taken(op, s, e);
        exp_tgt = model_target(p, o);
        lat     = exp_tk ? 2 + F : 2;
        check_eq("ready_before", 32'(br_ready), 32'd1);
        br_valid = 1'b1;
        br_op    = op;
        sltres   = s;
        eq       = e;
        pc       = p;
        offset   = o;
        @(posedge clk);
        #1;
        if (follow) begin
            br_valid = 1'b1;
            br_op    = nop;
            sltres   = ns;
            eq       = ne;
            pc       = np;
            offset   = no;
        end else begin
            br_valid = 1'b0;
            br_op    = 2'($urandom);
            sltres   = DW'($urandom);
            eq       = ~e;
            pc       = DW'($urandom);
            offset   = DW'($urandom);
        end
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check_eq("br_ready", 32'(br_ready), 32'(k == lat));
            check_eq("redirect", 32'(redirect), 32'(exp_tk && k == 1));
            check_eq("flush", 32'(flush), 32'(exp_tk && k >= 1 && k <= F));
            check_eq("resolved", 32'(resolved), 32'(k == lat));
            check_eq("taken", 32'(taken), 32'((k == lat) ? exp_tk : last_taken));
            check_eq("target_pc", 32'(target_pc), 32'((k == 0) ? last_target : exp_tgt));
        end
        last_taken  = exp_tk;
        last_target = exp_tgt;
        n_total++;
        if (exp_tk) n_taken++;
    endtask

    task automatic run_simple(input logic [1:0] op, input logic [DW-1:0] s, input logic e,
                              input logic [DW-1:0] p, input logic [DW-1:0] o);
        run_branch(op, s, e, p, o, 1'b0, 2'b00, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [1:0]    r_op;
        logic [DW-1:0] r_s;
        rst         = 1'b1;
        br_valid    = 1'b0;
        br_op       = 2'b00;
        sltres      = '0;
        eq          = 1'b0;
        pc          = '0;
        offset      = '0;
        last_taken  = 1'b0;
        last_target = '0;
        n_total     = 0;
        n_taken     = 0;

        #2;
        check_eq("rst_ready", 32'(br_ready), 32'd1);
        check_eq("rst_redirect", 32'(redirect), 32'd0);
        check_eq("rst_flush", 32'(flush), 32'd0);
        check_eq("rst_resolved", 32'(resolved), 32'd0);
        check_eq("rst_taken", 32'(taken), 32'd0);
        check_eq("rst_target", 32'(target_pc), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // BLT taken, BLT not taken, BNE backward with wrap
        run_simple(2'b00, 24'd1, 1'b0, 24'h000100, 24'h000010);
        run_simple(2'b00, 24'd0, 1'b0, 24'h000200, 24'h000004);
        run_simple(2'b11, 24'd0, 1'b0, 24'h000004, 24'hFFFFF8);
        check_eq("wrap_target", 32'(target_pc), 32'h00FFFFFC);

        // BEQ taken while inputs change and br_valid is held for a second request
        run_branch(2'b10, 24'd0, 1'b1, 24'h001000, 24'h000020,
                   1'b1, 2'b01, 24'h800000, 1'b0, 24'h002000, 24'h000008);
        run_simple(2'b01, 24'h800000, 1'b0, 24'h002000, 24'h000008);

        // Reset asserted in the first FLUSH cycle
        br_valid = 1'b1;
        br_op    = 2'b00;
        sltres   = 24'd1;
        eq       = 1'b0;
        pc       = 24'h000300;
        offset   = 24'h000040;
        @(posedge clk);
        #1 br_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("pre_rst_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_flush", 32'(flush), 32'd0);
        check_eq("midrst_redirect", 32'(redirect), 32'd0);
        check_eq("midrst_ready", 32'(br_ready), 32'd1);
        check_eq("midrst_target", 32'(target_pc), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        last_taken  = 1'b0;
        last_target = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("postrst_resolved", 32'(resolved), 32'd0);
            check_eq("postrst_flush", 32'(flush), 32'd0);
        end
`ifdef BR_STATS_EN
        check_eq("stat_total_rst", 32'(stat_total), 32'd0);
        check_eq("stat_taken_rst", 32'(stat_taken), 32'd0);
`endif
        n_total = 0;
        n_taken = 0;
        run_simple(2'b10, 24'd5, 1'b1, 24'h000400, 24'hFFFF00);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       r_s = '0;
                1:       r_s = 24'd1;
                2:       r_s = DW'(1) << $urandom_range(0, DW - 1);
                default: r_s = DW'($urandom);
            endcase
            run_simple(r_op, r_s, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
        end

`ifdef BR_STATS_EN
        check_eq("stat_total", 32'(stat_total), 32'(n_total));
        check_eq("stat_taken", 32'(stat_taken), 32'(n_taken));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
